// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   MIN_DIV      smallest divisor the divider accepts
//   run_state_e  enable FSM encoding
//   div_valid()  range check for a requested divisor
//   half()       floor(value/2) via shift; the high-phase length in clk cycles
package clk_div_pkg;

  localparam int unsigned MIN_DIV = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } run_state_e;

  function automatic logic div_valid(input int unsigned value, input int unsigned max);
    return (value >= MIN_DIV) && (value <= max);
  endfunction

  function automatic int unsigned half(input int unsigned value);
    return value >> 1;
  endfunction

endpackage

// File: rtl/clk_div_n_if.sv
// Control/status bundle between the divider and whatever drives it.
// Latency: n/a (wires only).
// Backpressure: none; div_load is a fire-and-forget strobe, err reports rejects.
//   master: drives en, div, div_load; observes clk_out, rise_tick, cur_div, err
//   slave : the divider itself
// MAX_DIV must match the divider's MAX_DIV so the divisor widths line up.
interface clk_div_n_if #(
  parameter int MAX_DIV = 16
);
  localparam int W = $clog2(MAX_DIV + 1);

  logic         en;
  logic [W-1:0] div;
  logic         div_load;
  logic         clk_out;
  logic         rise_tick;
  logic [W-1:0] cur_div;
  logic         err;

  modport master (
    output en, div, div_load,
    input  clk_out, rise_tick, cur_div, err
  );

  modport slave (
    input  en, div, div_load,
    output clk_out, rise_tick, cur_div, err
  );

endinterface

// File: rtl/half_cycle_ext.sv
// Falling-edge half-cycle extension for odd divisors; the only negedge logic.
// Latency: clk_o follows pos_i combinationally, extension lands half a clk later.
// Backpressure: none.
//   clk   in  source clock (negedge used here)
//   reset in  synchronous active-high, sampled on negedge
//   pos_i in  posedge-registered high phase
//   odd_i in  current divisor is odd (registered, changes only on posedge)
//   clk_o out divided clock
module half_cycle_ext (
  input  logic clk,
  input  logic reset,
  input  logic pos_i,
  input  logic odd_i,
  output logic clk_o
);

  logic neg_q;

  // Gating with odd_i at capture keeps neg_q at 0 for even divisors, so the
  // output is always a plain OR of two flops with no select mux to glitch.
  always_ff @(negedge clk) begin
    if (reset) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_i & odd_i;
    end
  end

  assign clk_o = pos_i | neg_q;

endmodule

// File: rtl/clk_div_n.sv
// Programmable divide-by-N clock generator, 50% duty for even and odd N.
// Latency: clk_out rises on the posedge that samples en while idle; divisor loads apply at the next period boundary.
// Backpressure: none; invalid loads are dropped and flagged with a one-cycle err pulse.
//   clk, reset : source clock (both edges), synchronous active-high reset
//   bus.en      run request; a stop lets the current period finish
//   bus.div / bus.div_load : divisor request and capture strobe
//   bus.clk_out : divided clock      bus.rise_tick : clk-domain strobe at each rise
//   bus.cur_div : divisor in effect  bus.err       : rejected-load pulse
module clk_div_n
  import clk_div_pkg::*;
#(
  parameter int MAX_DIV     = 16,
  parameter int DEFAULT_DIV = 3   // must lie in [MIN_DIV, MAX_DIV]
) (
  input  logic        clk,
  input  logic        reset,
  clk_div_n_if.slave  bus
);

  localparam int W = $clog2(MAX_DIV + 1);
  localparam logic [W-1:0] DEF_DIV = W'(DEFAULT_DIV);

  run_state_e   state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] cur_div_q, cur_div_d;
  logic [W-1:0] pend_div_q, pend_div_d;
  logic         pend_valid_q, pend_valid_d;
  logic         pos_q, pos_d;
  logic         rise_tick_q, rise_tick_d;
  logic         err_q, err_d;

  logic running;
  logic running_d;
  logic wrap;
  logic boundary;
  logic div_ok;

  assign running  = (state_q != IDLE);
  assign wrap     = running && (cnt_q == cur_div_q - W'(1));
  // A period boundary is the wrap edge, or any edge while nothing is being emitted.
  assign boundary = wrap || !running;
  assign div_ok   = div_valid(32'(bus.div), MAX_DIV);

  always_comb begin
    state_d      = state_q;
    cur_div_d    = cur_div_q;
    pend_div_d   = pend_div_q;
    pend_valid_d = pend_valid_q;
    err_d        = bus.div_load && !div_ok;

    // Retire the pending divisor first; a load in the same cycle re-arms it,
    // so that new value waits for the following boundary.
    if (boundary && pend_valid_q) begin
      cur_div_d    = pend_div_q;
      pend_valid_d = 1'b0;
    end
    if (bus.div_load && div_ok) begin
      pend_div_d   = bus.div;
      pend_valid_d = 1'b1;
    end

    // STOPPING only remembers that en dropped; the period still runs to the wrap.
    unique case (state_q)
      IDLE: begin
        if (bus.en) state_d = RUN;
      end
      RUN, STOPPING: begin
        if (wrap) state_d = bus.en ? RUN : IDLE;
        else      state_d = bus.en ? RUN : STOPPING;
      end
      default: state_d = IDLE;
    endcase

    running_d = (state_d != IDLE);
    cnt_d     = (running && !wrap) ? cnt_q + W'(1) : '0;

    // The high phase uses the divisor of the period being entered, so a
    // change at the wrap edge shapes the whole new period consistently.
    pos_d       = running_d && (cnt_d < W'(half(32'(cur_div_d))));
    rise_tick_d = running_d && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cur_div_q    <= DEF_DIV;
      pend_div_q   <= DEF_DIV;
      pend_valid_q <= 1'b0;
      pos_q        <= 1'b0;
      rise_tick_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_div_q    <= cur_div_d;
      pend_div_q   <= pend_div_d;
      pend_valid_q <= pend_valid_d;
      pos_q        <= pos_d;
      rise_tick_q  <= rise_tick_d;
      err_q        <= err_d;
    end
  end

  half_cycle_ext u_half_cycle_ext (
    .clk   (clk),
    .reset (reset),
    .pos_i (pos_q),
    .odd_i (cur_div_q[0]),
    .clk_o (bus.clk_out)
  );

  assign bus.rise_tick = rise_tick_q;
  assign bus.cur_div   = cur_div_q;
  assign bus.err       = err_q;

endmodule
